// File: rtl/fp_add_pkg.sv
// Shared widths, FSM states and comparator codes for the FP adder alignment stage.
// Mantissa-small layout is {hidden, fraction, G, R, S}.
package fp_add_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int GRS_W  = 3;
  localparam int SH_MAX = MAN_W + 4;
  localparam int SH_W   = 5;
  localparam int MS_W   = MAN_W + 1 + GRS_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    EQ   = 2'd0,
    A_GT = 2'd1,
    B_GT = 2'd2
  } bigger_e;

endpackage

// File: rtl/mantissa_align_if.sv
// Operand-in / aligned-out bundle with valid/ready on both sides.
// slave = alignment stage, master = upstream comparator plus downstream adder.
interface mantissa_align_if;
  import fp_add_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp1;
  logic [EXP_W-1:0] exp2;
  logic [MAN_W-1:0] man1;
  logic [MAN_W-1:0] man2;
  logic [EXP_W-1:0] dif;
  logic [1:0]       bigger;

  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W:0]   man_big;
  logic [MS_W-1:0]  man_small;
  logic             swapped;

  modport slave (
    input  in_valid, exp1, exp2, man1, man2, dif, bigger, out_ready,
    output in_ready, out_valid, exp_out, man_big, man_small, swapped
  );

  modport master (
    output in_valid, exp1, exp2, man1, man2, dif, bigger, out_ready,
    input  in_ready, out_valid, exp_out, man_big, man_small, swapped
  );
endinterface

// File: rtl/sticky_shr.sv
// One bounded right shift; every bit pushed out (including the old sticky) is ORed into bit 0.
module sticky_shr #(
  parameter int W    = 27,
  parameter int SH_W = 5
) (
  input  logic [W-1:0]    i_din,
  input  logic [SH_W-1:0] i_sh,
  output logic [W-1:0]    o_dout
);
  logic [W-1:0] w_mask;
  logic [W-1:0] w_shr;
  logic         w_sticky;

  assign w_mask   = ~({W{1'b1}} << i_sh);
  assign w_shr    = i_din >> i_sh;
  assign w_sticky = |(i_din & w_mask);
  assign o_dout   = {w_shr[W-1:1], w_shr[0] | w_sticky};
endmodule

// File: rtl/mantissa_align.sv
// FP adder alignment: orders operands by exponent, restores hidden bits and shifts the
// smaller mantissa right STEP bits per cycle into {hid,frac,G,R,S}.
module mantissa_align
  import fp_add_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic            clk,
  input  logic            rst,
  mantissa_align_if.slave bus
);
  localparam logic [SH_W-1:0] STEP_C = SH_W'(STEP);

  state_t           r_state;
  logic [SH_W-1:0]  r_rem;
  logic [MS_W-1:0]  r_small;
  logic [MAN_W:0]   r_big;
  logic [EXP_W-1:0] r_exp;
  logic             r_swapped;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_hid1;
  logic             w_hid2;
  logic             w_b_gt;
  logic [SH_W-1:0]  w_n;
  logic [SH_W-1:0]  w_s;
  logic [MS_W-1:0]  w_small_nxt;

  assign w_hid1 = |bus.exp1;
  assign w_hid2 = |bus.exp2;
  assign w_b_gt = (bus.bigger == B_GT);

  // Equal or illegal comparator codes mean no shift; stale dif is ignored.
  always_comb begin
    w_n = '0;
    if (bus.bigger == A_GT || bus.bigger == B_GT)
      w_n = (bus.dif > EXP_W'(SH_MAX)) ? SH_W'(SH_MAX) : bus.dif[SH_W-1:0];
  end

  assign w_s = (r_rem > STEP_C) ? STEP_C : r_rem;

  sticky_shr #(
    .W    (MS_W),
    .SH_W (SH_W)
  ) u_shr (
    .i_din  (r_small),
    .i_sh   (w_s),
    .o_dout (w_small_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_small     <= '0;
      r_big       <= '0;
      r_exp       <= '0;
      r_swapped   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_exp      <= w_b_gt ? bus.exp2 : bus.exp1;
            r_big      <= w_b_gt ? {w_hid2, bus.man2} : {w_hid1, bus.man1};
            r_small    <= w_b_gt ? {w_hid1, bus.man1, {GRS_W{1'b0}}}
                                 : {w_hid2, bus.man2, {GRS_W{1'b0}}};
            r_swapped  <= w_b_gt;
            r_rem      <= w_n;
            r_in_ready <= 1'b0;
            if (w_n == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_small <= w_small_nxt;
          r_rem   <= r_rem - w_s;
          if (r_rem == w_s) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.exp_out   = r_exp;
  assign bus.man_big   = r_big;
  assign bus.man_small = r_small;
  assign bus.swapped   = r_swapped;
endmodule

// File: tb/tb_mantissa_align.sv
// Bench for mantissa_align (STEP=8): directed vector table, hold/reset sequences,
// and randomized bundles checked against a one-shot arithmetic reference model.
module tb_mantissa_align;
  import fp_add_pkg::*;

  typedef struct {
    logic [7:0]  exp1;
    logic [22:0] man1;
    logic [7:0]  exp2;
    logic [22:0] man2;
    logic [7:0]  dif;
    logic [1:0]  bigger;
    logic [7:0]  x_exp;
    logic [23:0] x_big;
    logic [26:0] x_small;
    logic        x_sw;
    int          x_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[9];

  mantissa_align_if bus();

  mantissa_align #(.STEP(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] e1, input logic [22:0] m1,
                              input logic [7:0] e2, input logic [22:0] m2,
                              input logic [7:0] d, input logic [1:0] bg,
                              input logic [7:0] xe, input logic [23:0] xb,
                              input logic [26:0] xs, input logic xw, input int xl);
    vec_t v;
    v.exp1 = e1; v.man1 = m1; v.exp2 = e2; v.man2 = m2; v.dif = d; v.bigger = bg;
    v.x_exp = xe; v.x_big = xb; v.x_small = xs; v.x_sw = xw; v.x_lat = xl;
    return v;
  endfunction

  // Whole shift done at once with plain arithmetic.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    logic [23:0] a, b, sm;
    logic [26:0] s, low;
    int n;
    r = v;
    a = {(v.exp1 != 0), v.man1};
    b = {(v.exp2 != 0), v.man2};
    r.x_sw = (v.bigger == 2);
    n = (v.bigger == 1 || v.bigger == 2) ? ((v.dif > 27) ? 27 : int'(v.dif)) : 0;
    r.x_exp = r.x_sw ? v.exp2 : v.exp1;
    r.x_big = r.x_sw ? b : a;
    sm = r.x_sw ? a : b;
    s = {sm, 3'b000};
    if (n >= 27) begin
      r.x_small = {26'b0, (s != 0)};
    end else begin
      low = s & ((27'd1 << n) - 27'd1);
      r.x_small = s >> n;
      r.x_small[0] = r.x_small[0] | (low != 0);
    end
    r.x_lat = (n + 7) / 8;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.exp1 = v.exp1; bus.man1 = v.man1; bus.exp2 = v.exp2; bus.man2 = v.man2;
    bus.dif = v.dif; bus.bigger = v.bigger;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic do_op(input vec_t v, input int hold);
    int lat = 0;
    wait_ready();
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, v.x_lat);
    chk("exp_out", {24'b0, bus.exp_out}, {24'b0, v.x_exp});
    chk("man_big", {8'b0, bus.man_big}, {8'b0, v.x_big});
    chk("man_small", {5'b0, bus.man_small}, {5'b0, v.x_small});
    chk("swapped", {31'b0, bus.swapped}, {31'b0, v.x_sw});
    chk("in_ready_done", {31'b0, bus.in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("hold_man_small", {5'b0, bus.man_small}, {5'b0, v.x_small});
      chk("hold_exp_out", {24'b0, bus.exp_out}, {24'b0, v.x_exp});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [7:0] e1, e2;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exp1 = '0; bus.exp2 = '0; bus.man1 = '0; bus.man2 = '0; bus.dif = '0; bus.bigger = '0;

    tbl[0] = mk(8'h82, 23'h0, 8'h80, 23'h400000, 8'd2, 2'd1, 8'h82, 24'h800000, 27'h1800000, 1'b0, 1);
    tbl[1] = mk(8'h7F, 23'h1, 8'h9D, 23'h0, 8'd30, 2'd2, 8'h9D, 24'h800000, 27'h1, 1'b1, 4);
    tbl[2] = mk(8'h90, 23'h123456, 8'h90, 23'h7FFFFF, 8'h55, 2'd0, 8'h90, 24'h923456, 27'h7FFFFF8, 1'b0, 0);
    tbl[3] = mk(8'h01, 23'h0, 8'h00, 23'h400000, 8'd1, 2'd1, 8'h01, 24'h800000, 27'h1000000, 1'b0, 1);
    tbl[4] = mk(8'h10, 23'h0, 8'h10, 23'h0, 8'd5, 2'd3, 8'h10, 24'h800000, 27'h4000000, 1'b0, 0);
    tbl[5] = mk(8'hA0, 23'h0, 8'h85, 23'h0, 8'd27, 2'd1, 8'hA0, 24'h800000, 27'h1, 1'b0, 4);
    tbl[6] = mk(8'hA0, 23'h0, 8'h86, 23'h0, 8'd26, 2'd1, 8'hA0, 24'h800000, 27'h1, 1'b0, 4);
    tbl[7] = mk(8'h50, 23'h0, 8'h48, 23'h1, 8'd8, 2'd1, 8'h50, 24'h800000, 27'h40001, 1'b0, 1);
    tbl[8] = mk(8'h40, 23'h1, 8'h49, 23'h7, 8'd9, 2'd2, 8'h49, 24'h800007, 27'h20001, 1'b1, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_man_small", {5'b0, bus.man_small}, 32'd0);
    chk("rst_man_big", {8'b0, bus.man_big}, 32'd0);
    chk("rst_exp_out", {24'b0, bus.exp_out}, 32'd0);
    chk("rst_swapped", {31'b0, bus.swapped}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_op(tbl[i], (i == 0) ? 5 : 0);

    // Reset asserted during the second SHIFT cycle of a long shift.
    wait_ready();
    drive(tbl[1]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_man_small", {5'b0, bus.man_small}, 32'd0);
    chk("midrst_exp_out", {24'b0, bus.exp_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(tbl[1], 0);

    for (int k = 0; k < 150; k++) begin
      e1 = 8'($urandom_range(0, 255));
      e2 = ($urandom_range(0, 5) == 0) ? e1 : 8'($urandom_range(0, 255));
      v.exp1 = e1; v.exp2 = e2;
      v.man1 = 23'($urandom); v.man2 = 23'($urandom);
      v.bigger = (e1 > e2) ? 2'd1 : (e2 > e1) ? 2'd2 : 2'd0;
      v.dif = (e1 > e2) ? e1 - e2 : e2 - e1;
      if ($urandom_range(0, 7) == 0) begin
        v.bigger = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
        v.dif = 8'($urandom);
      end
      do_op(ref_model(v), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
